rename_map_table: RTL and testbench
===================================

# rename_map_table

Speculative/architectural register alias table for the rename stage, sitting directly downstream of the physical-register free list. It performs the following for a group of up to DECODE_WIDTH decoded instructions each cycle:
- translates architectural source/destination registers to physical registers;
- draws new destination registers from the free list;
- registers the result for dispatch.

On commit it updates the architectural table and returns the superseded physical register to the free list. On flush it restores the speculative table from the architectural one.

## Interface
Parameters:
- DECODE_WIDTH, 2, rename group width
- COMMIT_WIDTH, 2, commit group width
- ARCH_REG_NUM, 32, architectural registers (power of 2)
- PHY_REG_NUM, 64, physical registers (power of 2); AW = log2(ARCH_REG_NUM), PW = log2(PHY_REG_NUM)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush
- rename_valid_i  in  DECODE_WIDTH  per-slot valid, contiguous from bit 0
- rename_ready_o  out  1  group accepted when any valid and ready
- src0_areg_i, src1_areg_i, dest_areg_i  in  DECODE_WIDTH×AW  architectural operands
- dest_we_i  in  DECODE_WIDTH  slot writes a destination
- alloc_valid_o  out  DECODE_WIDTH  free-list request, compacted, contiguous from bit 0
- alloc_ready_i  in  1  free list can supply DECODE_WIDTH registers; independent of alloc_valid_o
- alloc_preg_i  in  DECODE_WIDTH×PW  free-list output, index k serves k-th request
- out_valid_o  out  DECODE_WIDTH  registered renamed slots
- out_ready_i  in  1  dispatch accepts output register
- out_psrc0_o, out_psrc1_o, out_pdest_o  out  DECODE_WIDTH×PW  renamed operands
- commit_valid_i  in  COMMIT_WIDTH  contiguous from bit 0
- commit_areg_i  in  COMMIT_WIDTH×AW, commit_preg_i  in  COMMIT_WIDTH×PW  committed mapping
- free_valid_o  out  COMMIT_WIDTH  superseded register release, contiguous from bit 0
- free_preg_o  out  COMMIT_WIDTH×PW  released register

## Operation
- State:
  - spec_rat and arch_rat, ARCH_REG_NUM×PW each;
  - output register (valid vector + operands);
  - free output register.
- Reset: spec_rat[i]=arch_rat[i]=i; out_valid_o=0, all out_* operands 0; free_valid_o=0, free_preg_o=0.
- Areg 0 is hardwired zero:
  - a slot with dest_areg=0 makes no allocation, gets pdest=0, and writes no table;
  - src areg 0 maps to preg 0.
- Allocation request set: slot i requests iff rename_valid_i[i] & dest_we_i[i] & dest_areg_i[i]!=0.
  - alloc_valid_o holds popcount(requests) ones from bit 0, only when the group fires, otherwise 0.
- Fire: fire = |rename_valid_i & rename_ready_o. rename_ready_o = alloc_ready_i & (!out_valid_o-any | out_ready_i) & !flush_i.
- Group is all-or-nothing.
- Source lookup for slot i: if an earlier slot j<i in the group writes the same nonzero areg, use pdest of the highest such j; else spec_rat.
- spec_rat write on fire: per-slot in order, later slot wins on equal dest_areg.
- Output register:
  - loads on fire;
  - clears valid when out_ready_i and no fire;
  - holds while out_ready_i=0.
- Commit, every cycle:
  - for each valid slot k, old = arch_rat[areg], with intra-group bypass (earlier same-areg commit in the group supplies old);
  - arch_rat[areg] <= preg, later slot wins;
  - commit of areg 0 is ignored and produces no free.
- Free output: a registered, compacted list of old values; free_valid_o contiguous from bit 0. Consumer is always ready.
- Flush:
  - output valid cleared;
  - spec_rat <= arch_rat including same-cycle commit updates;
  - no allocation that cycle;
  - commit and free processing proceed normally.

## Timing
- Rename latency: 1 cycle, fire at edge N → out_valid_o at N+1.
- Back-to-back groups when out_ready_i=1; a dependent next group sees spec_rat updated.
- Commit → free_valid_o: 1 cycle. Commit → arch_rat visible: next cycle.
- alloc_valid_o is combinational from rename_valid_i, dest_*, alloc_ready_i, out_ready_i, flush_i; no path from alloc_valid_o back to ready.
- rst_n asserted mid-operation: all state immediately returns to reset values.

## Test plan
- Reset, group {src0=5,src1=7}: psrc0=5, psrc1=7 at N+1; out_valid_o=01.
- Slot0 dest r3 with alloc preg 40; slot1 src0=r3, dest r3 with alloc preg 41 → slot1 psrc0=40, pdest=41; alloc_valid_o=11; next group src r3 → 41.
- Slot0 dest r0 we=1, slot1 dest r4 → alloc_valid_o=01, slot1 pdest=alloc_preg_i[0], slot0 pdest=0.
- out_ready_i=0 with output full → rename_ready_o=0, alloc_valid_o=0, outputs stable; alloc_ready_i=0 → same.
- Commit {r3→40, r3→41} same cycle → free_preg_o = {3, 40}, free_valid_o=11, arch_rat[3]=41.
- After speculative r5→50 with commit r5→45 in the same cycle as flush_i → next lookup r5 gives 45, out_valid_o=0.

Source files
------------

// File: rtl/rename_map_table.sv
// Rename-stage register alias table: a speculative and an architectural map
// from architectural to physical registers. Rename groups are translated,
// allocated from the free list and registered for dispatch. Commits update the
// architectural map and release superseded registers. A flush copies the
// architectural map back into the speculative one.
module rename_map_table #(
    parameter int DECODE_WIDTH = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int ARCH_REG_NUM = 32,
    parameter int PHY_REG_NUM  = 64,
    localparam int AW = $clog2(ARCH_REG_NUM),
    localparam int PW = $clog2(PHY_REG_NUM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic [DECODE_WIDTH-1:0]      rename_valid_i,
    output logic                         rename_ready_o,
    input  logic [DECODE_WIDTH*AW-1:0]   src0_areg_i,
    input  logic [DECODE_WIDTH*AW-1:0]   src1_areg_i,
    input  logic [DECODE_WIDTH*AW-1:0]   dest_areg_i,
    input  logic [DECODE_WIDTH-1:0]      dest_we_i,
    output logic [DECODE_WIDTH-1:0]      alloc_valid_o,
    input  logic                         alloc_ready_i,
    input  logic [DECODE_WIDTH*PW-1:0]   alloc_preg_i,
    output logic [DECODE_WIDTH-1:0]      out_valid_o,
    input  logic                         out_ready_i,
    output logic [DECODE_WIDTH*PW-1:0]   out_psrc0_o,
    output logic [DECODE_WIDTH*PW-1:0]   out_psrc1_o,
    output logic [DECODE_WIDTH*PW-1:0]   out_pdest_o,
    input  logic [COMMIT_WIDTH-1:0]      commit_valid_i,
    input  logic [COMMIT_WIDTH*AW-1:0]   commit_areg_i,
    input  logic [COMMIT_WIDTH*PW-1:0]   commit_preg_i,
    output logic [COMMIT_WIDTH-1:0]      free_valid_o,
    output logic [COMMIT_WIDTH*PW-1:0]   free_preg_o
);

    logic [PW-1:0]              spec_q [ARCH_REG_NUM];
    logic [PW-1:0]              spec_d [ARCH_REG_NUM];
    logic [PW-1:0]              arch_q [ARCH_REG_NUM];
    logic [PW-1:0]              arch_d [ARCH_REG_NUM];

    logic [DECODE_WIDTH-1:0]    out_valid_q;
    logic [DECODE_WIDTH*PW-1:0] out_psrc0_q, out_psrc1_q, out_pdest_q;
    logic [COMMIT_WIDTH-1:0]    free_valid_q, free_valid_d;
    logic [COMMIT_WIDTH*PW-1:0] free_preg_q, free_preg_d;

    logic [DECODE_WIDTH-1:0]    req;
    logic                       fire;
    logic [DECODE_WIDTH*PW-1:0] psrc0_c, psrc1_c, pdest_c;

    // Handshake: accept a group only when the free list can supply a full
    // group, the output register can take it, and no flush is in progress.
    always_comb begin
        rename_ready_o = alloc_ready_i & (~(|out_valid_q) | out_ready_i) & ~flush_i;
        fire           = (|rename_valid_i) & rename_ready_o;
    end

    // Rename translation: allocation compaction, destination assignment and
    // source lookup with bypass from earlier slots of the same group.
    always_comb begin
        int           nreq;
        logic [AW-1:0] a0, a1, dj;
        nreq          = 0;
        req           = '0;
        pdest_c       = '0;
        psrc0_c       = '0;
        psrc1_c       = '0;
        alloc_valid_o = '0;
        a0            = '0;
        a1            = '0;
        dj            = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            req[i] = rename_valid_i[i] & dest_we_i[i] & (dest_areg_i[i*AW +: AW] != '0);
        end
        // The k-th requesting slot takes free-list entry k.
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (req[i]) begin
                for (int k = 0; k < DECODE_WIDTH; k++) begin
                    if (k == nreq) begin
                        pdest_c[i*PW +: PW] = alloc_preg_i[k*PW +: PW];
                        alloc_valid_o[k]    = fire;
                    end
                end
                nreq = nreq + 1;
            end
        end
        // Later matching slot overrides earlier ones, so the highest j wins.
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            a0 = src0_areg_i[i*AW +: AW];
            a1 = src1_areg_i[i*AW +: AW];
            psrc0_c[i*PW +: PW] = spec_q[a0];
            psrc1_c[i*PW +: PW] = spec_q[a1];
            for (int j = 0; j < DECODE_WIDTH; j++) begin
                dj = dest_areg_i[j*AW +: AW];
                if (j < i && req[j] && dj == a0) psrc0_c[i*PW +: PW] = pdest_c[j*PW +: PW];
                if (j < i && req[j] && dj == a1) psrc1_c[i*PW +: PW] = pdest_c[j*PW +: PW];
            end
            if (a0 == '0) psrc0_c[i*PW +: PW] = '0;
            if (a1 == '0) psrc1_c[i*PW +: PW] = '0;
        end
    end

    // Commit: walk slots in order so an earlier same-register commit supplies
    // the superseded mapping of a later one; compact released registers.
    always_comb begin
        int           nfree;
        logic [AW-1:0] ca;
        nfree        = 0;
        ca           = '0;
        arch_d       = arch_q;
        free_valid_d = '0;
        free_preg_d  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            ca = commit_areg_i[k*AW +: AW];
            if (commit_valid_i[k] && ca != '0) begin
                for (int p = 0; p < COMMIT_WIDTH; p++) begin
                    if (p == nfree) begin
                        free_preg_d[p*PW +: PW] = arch_d[ca];
                        free_valid_d[p]         = 1'b1;
                    end
                end
                arch_d[ca] = commit_preg_i[k*PW +: PW];
                nfree      = nfree + 1;
            end
        end
    end

    // Speculative map: restored from the post-commit architectural map on
    // flush, otherwise updated by the fired group with later slots winning.
    always_comb begin
        spec_d = spec_q;
        if (flush_i) begin
            spec_d = arch_d;
        end else if (fire) begin
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                if (req[i]) spec_d[dest_areg_i[i*AW +: AW]] = pdest_c[i*PW +: PW];
            end
        end
    end

    // State registers: both maps, the dispatch output register and the free
    // output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ARCH_REG_NUM; r++) begin
                spec_q[r] <= PW'(r);
                arch_q[r] <= PW'(r);
            end
            out_valid_q  <= '0;
            out_psrc0_q  <= '0;
            out_psrc1_q  <= '0;
            out_pdest_q  <= '0;
            free_valid_q <= '0;
            free_preg_q  <= '0;
        end else begin
            spec_q       <= spec_d;
            arch_q       <= arch_d;
            free_valid_q <= free_valid_d;
            free_preg_q  <= free_preg_d;
            if (flush_i) begin
                out_valid_q <= '0;
            end else if (fire) begin
                out_valid_q <= rename_valid_i;
                out_psrc0_q <= psrc0_c;
                out_psrc1_q <= psrc1_c;
                out_pdest_q <= pdest_c;
            end else if (out_ready_i) begin
                out_valid_q <= '0;
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_psrc0_o  = out_psrc0_q;
    assign out_psrc1_o  = out_psrc1_q;
    assign out_pdest_o  = out_pdest_q;
    assign free_valid_o = free_valid_q;
    assign free_preg_o  = free_preg_q;

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table with hand-computed expectations.
module tb_rename_map_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [1:0]  rename_valid_i;
    logic        rename_ready_o;
    logic [9:0]  src0_areg_i, src1_areg_i, dest_areg_i;
    logic [1:0]  dest_we_i;
    logic [1:0]  alloc_valid_o;
    logic        alloc_ready_i;
    logic [11:0] alloc_preg_i;
    logic [1:0]  out_valid_o;
    logic        out_ready_i;
    logic [11:0] out_psrc0_o, out_psrc1_o, out_pdest_o;
    logic [1:0]  commit_valid_i;
    logic [9:0]  commit_areg_i;
    logic [11:0] commit_preg_i;
    logic [1:0]  free_valid_o;
    logic [11:0] free_preg_o;

    int nvec = 0;
    int nerr = 0;

    rename_map_table dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .rename_valid_i(rename_valid_i), .rename_ready_o(rename_ready_o),
        .src0_areg_i(src0_areg_i), .src1_areg_i(src1_areg_i),
        .dest_areg_i(dest_areg_i), .dest_we_i(dest_we_i),
        .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i),
        .alloc_preg_i(alloc_preg_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_psrc0_o(out_psrc0_o), .out_psrc1_o(out_psrc1_o), .out_pdest_o(out_pdest_o),
        .commit_valid_i(commit_valid_i), .commit_areg_i(commit_areg_i),
        .commit_preg_i(commit_preg_i),
        .free_valid_o(free_valid_o), .free_preg_o(free_preg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; rename_valid_i = 0; dest_we_i = 0;
        src0_areg_i = 0; src1_areg_i = 0; dest_areg_i = 0; alloc_preg_i = 0;
        commit_valid_i = 0; commit_areg_i = 0; commit_preg_i = 0;
    endtask

    initial begin
        rst_n = 0; out_ready_i = 1; alloc_ready_i = 1;
        idle();
        tick(); tick();
        // Reset state
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_psrc0", 32'(out_psrc0_o), 0);
        chk("rst_pdest", 32'(out_pdest_o), 0);
        chk("rst_free_valid", 32'(free_valid_o), 0);
        chk("rst_free_preg", 32'(free_preg_o), 0);
        rst_n = 1;
        tick();

        // Plain lookup after reset: r5 -> 5, r7 -> 7
        rename_valid_i = 2'b01; src0_areg_i = {5'd0, 5'd5}; src1_areg_i = {5'd0, 5'd7};
        #1;
        chk("ready_idle", 32'(rename_ready_o), 1);
        chk("alloc_none", 32'(alloc_valid_o), 0);
        tick();
        chk("g1_valid", 32'(out_valid_o), 2'b01);
        chk("g1_psrc0", 32'(out_psrc0_o[5:0]), 5);
        chk("g1_psrc1", 32'(out_psrc1_o[5:0]), 7);

        // Intra-group dependency: slot1 reads r3 written by slot0
        rename_valid_i = 2'b11; dest_we_i = 2'b11;
        dest_areg_i = {5'd3, 5'd3}; src0_areg_i = {5'd3, 5'd0}; src1_areg_i = {5'd9, 5'd0};
        alloc_preg_i = {6'd41, 6'd40};
        #1;
        chk("g2_alloc", 32'(alloc_valid_o), 2'b11);
        tick();
        chk("g2_valid", 32'(out_valid_o), 2'b11);
        chk("g2_pdest", 32'(out_pdest_o), {20'd0, 6'd41, 6'd40});
        chk("g2_psrc0", 32'(out_psrc0_o), {20'd0, 6'd40, 6'd0});
        chk("g2_psrc1", 32'(out_psrc1_o), {20'd0, 6'd9, 6'd0});

        // Back-to-back dependent group sees r3 -> 41
        idle();
        rename_valid_i = 2'b01; src0_areg_i = {5'd0, 5'd3}; src1_areg_i = {5'd0, 5'd4};
        tick();
        chk("g3_psrc0", 32'(out_psrc0_o[5:0]), 41);
        chk("g3_psrc1", 32'(out_psrc1_o[5:0]), 4);

        // Destination r0: no allocation, slot1 takes entry 0
        idle();
        rename_valid_i = 2'b11; dest_we_i = 2'b11; dest_areg_i = {5'd4, 5'd0};
        alloc_preg_i = {6'd34, 6'd33};
        #1;
        chk("g4_alloc", 32'(alloc_valid_o), 2'b01);
        tick();
        chk("g4_pdest", 32'(out_pdest_o), {20'd0, 6'd33, 6'd0});

        // Backpressure from dispatch
        idle();
        out_ready_i = 0;
        rename_valid_i = 2'b01; dest_we_i = 2'b01; dest_areg_i = {5'd0, 5'd6};
        alloc_preg_i = {6'd0, 6'd20};
        #1;
        chk("bp_ready", 32'(rename_ready_o), 0);
        chk("bp_alloc", 32'(alloc_valid_o), 0);
        tick();
        chk("bp_valid_hold", 32'(out_valid_o), 2'b11);
        chk("bp_pdest_hold", 32'(out_pdest_o), {20'd0, 6'd33, 6'd0});
        // Free list not ready: output drains, nothing fires
        out_ready_i = 1; alloc_ready_i = 0;
        #1;
        chk("nofree_ready", 32'(rename_ready_o), 0);
        chk("nofree_alloc", 32'(alloc_valid_o), 0);
        tick();
        chk("drain_valid", 32'(out_valid_o), 0);
        alloc_ready_i = 1;

        // Same-register double commit
        idle();
        commit_valid_i = 2'b11; commit_areg_i = {5'd3, 5'd3}; commit_preg_i = {6'd41, 6'd40};
        tick();
        chk("c1_free_valid", 32'(free_valid_o), 2'b11);
        chk("c1_free_preg", 32'(free_preg_o), {20'd0, 6'd40, 6'd3});
        idle();
        tick();
        chk("c1_free_clear", 32'(free_valid_o), 0);

        // Speculative r5 -> 50
        rename_valid_i = 2'b01; dest_we_i = 2'b01; dest_areg_i = {5'd0, 5'd5};
        alloc_preg_i = {6'd0, 6'd50};
        tick();
        chk("s5_pdest", 32'(out_pdest_o[5:0]), 50);

        // Flush with same-cycle commit r5 -> 45
        idle();
        flush_i = 1; rename_valid_i = 2'b01;
        commit_valid_i = 2'b01; commit_areg_i = {5'd0, 5'd5}; commit_preg_i = {6'd0, 6'd45};
        #1;
        chk("fl_ready", 32'(rename_ready_o), 0);
        chk("fl_alloc", 32'(alloc_valid_o), 0);
        tick();
        chk("fl_valid", 32'(out_valid_o), 0);
        chk("fl_free_valid", 32'(free_valid_o), 2'b01);
        chk("fl_free_preg", 32'(free_preg_o[5:0]), 5);

        // Lookup after flush; commit of r0 ignored alongside r7 -> 60
        idle();
        rename_valid_i = 2'b11;
        src0_areg_i = {5'd4, 5'd5}; src1_areg_i = {5'd6, 5'd3};
        commit_valid_i = 2'b11; commit_areg_i = {5'd7, 5'd0}; commit_preg_i = {6'd60, 6'd12};
        tick();
        chk("af_psrc0", 32'(out_psrc0_o), {20'd0, 6'd4, 6'd45});
        chk("af_psrc1", 32'(out_psrc1_o), {20'd0, 6'd6, 6'd41});
        chk("c0_free_valid", 32'(free_valid_o), 2'b01);
        chk("c0_free_preg", 32'(free_preg_o), {20'd0, 6'd0, 6'd7});

        // Asynchronous reset mid-cycle
        idle();
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(out_valid_o), 0);
        chk("arst_free", 32'(free_valid_o), 0);
        rst_n = 1;
        rename_valid_i = 2'b01; src0_areg_i = {5'd0, 5'd5};
        tick();
        chk("arst_map", 32'(out_psrc0_o[5:0]), 5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
